// File: rtl/dac_out_mc.sv
// dac_out_mc: multi-channel audio output stage; a frame FIFO drained once per sample
// period feeds per-channel 1-bit PWM or first-order sigma-delta modulators.
module dac_out_mc #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int SAMPLE_DIV = 1024,
    parameter int PWM_BITS   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic                        in_valid,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    output logic                        in_ready,
    input  logic                        clr_underrun,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CHANNELS-1:0]         analog
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int FW = CHANNELS * WIDTH;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic [FW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic [DW-1:0]       r_div;
    logic                r_mode;
    logic                r_under;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [WIDTH-1:0]    r_hold [CHANNELS];
    logic [WIDTH-1:0]    r_acc [CHANNELS];
    logic [PWM_BITS-1:0] r_duty [CHANNELS];
    logic [CHANNELS-1:0] r_analog;

    logic             w_full;
    logic             w_empty;
    logic             w_tick;
    logic             w_push;
    logic             w_pop;
    logic             w_mode_chg;
    logic             w_pwm_wrap;
    logic [WIDTH-1:0] w_u [CHANNELS];
    logic [WIDTH:0]   w_sum [CHANNELS];

    assign w_full     = r_count == DEPTH_C;
    assign w_empty    = r_count == '0;
    assign w_tick     = r_div == DIV_LAST;
    assign in_ready   = rst_n & ~w_full;
    assign w_push     = in_valid & in_ready;
    // a tick only pops what was stored before this edge, so pushes never fall through
    assign w_pop      = w_tick & ~w_empty;
    assign w_mode_chg = w_tick & (mode != r_mode);
    assign w_pwm_wrap = &r_pwm_cnt;
    assign underrun   = r_under;
    assign fifo_level = r_count;
    assign analog     = r_analog;

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            w_u[k]   = {~r_hold[k][WIDTH-1], r_hold[k][WIDTH-2:0]};
            w_sum[k] = {1'b0, r_acc[k]} + {1'b0, w_u[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_div     <= '0;
            r_mode    <= 1'b0;
            r_under   <= 1'b0;
            r_pwm_cnt <= '0;
            r_analog  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_hold[k] <= '0;
                r_acc[k]  <= '0;
                r_duty[k] <= '0;
            end
        end else begin
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            r_under <= (w_tick && w_empty) ? 1'b1 : clr_underrun ? 1'b0 : r_under;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
            if (w_tick) r_mode <= mode;
            r_pwm_cnt <= w_mode_chg ? '0 : r_pwm_cnt + 1'b1;
            // a mode switch restarts both modulators from a clean state
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_pop) r_hold[k] <= r_mem[r_rd_ptr][k*WIDTH +: WIDTH];
                r_acc[k]    <= w_mode_chg ? '0 : w_sum[k][WIDTH-1:0];
                r_duty[k]   <= w_mode_chg ? '0 : w_pwm_wrap ? w_u[k][WIDTH-1 -: PWM_BITS] : r_duty[k];
                r_analog[k] <= r_mode ? w_sum[k][WIDTH] : (r_pwm_cnt < r_duty[k]);
            end
        end
    end
endmodule

// File: tb/tb_dac_out_mc.sv
// tb_dac_out_mc: randomized scoreboard bench for dac_out_mc; a sample-period model predicts
// FIFO/underrun state and the exact per-channel output pattern of every period.
`timescale 1ns/1ps
module tb_dac_out_mc;
    localparam int CH    = 2;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int DIV   = 512;
    localparam int PB    = 8;
    localparam int PER   = 1 << PB;
    localparam int FULL  = 1 << W;
    localparam int MID   = 1 << (W - 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mode = 1'b0;
    logic              in_valid = 1'b0;
    logic              clr_underrun = 1'b0;
    logic [CH*W-1:0]   in_data = '0;
    logic              in_ready;
    logic              underrun;
    logic [2:0]        fifo_level;
    logic [CH-1:0]     analog;

    dac_out_mc #(.CHANNELS(CH), .WIDTH(W), .FIFO_DEPTH(DEPTH), .SAMPLE_DIV(DIV), .PWM_BITS(PB)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clr_underrun(clr_underrun), .underrun(underrun),
        .fifo_level(fifo_level), .analog(analog)
    );

    always #5 clk = ~clk;

    // one entry per sample period: start edge, modulation mode, offset-binary samples, start residue
    typedef struct { int s; bit sd; int u0; int u1; int a0; int a1; } win_t;
    win_t        sb[$];
    logic [31:0] fq[$];
    int          n = 0;
    bit          m_live = 0, m_rst = 0, m_sd = 0, m_under = 0;
    int          hold0 = 0, hold1 = 0, res0 = 0, res1 = 0;
    int          checks = 0, passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, n, act, exp);
    endtask

    // reference model: FIFO as a queue, each tick starts a new sample period
    initial begin
        bit rn, v, c, md, sw, empty_tick;
        logic [31:0] d, f;
        int lvl;
        forever begin
            @(posedge clk);
            rn = rst_n; v = in_valid; c = clr_underrun; md = mode; d = in_data;
            if (!rn) begin
                fq.delete(); sb.delete();
                n = 0; m_under = 0; m_sd = 0; hold0 = 0; hold1 = 0; res0 = 0; res1 = 0;
                m_live = 1; m_rst = 1;
                sb.push_back('{0, 1'b0, MID, MID, 0, 0});
            end else begin
                m_rst = 0;
                n++;
                lvl = fq.size();
                empty_tick = (n % DIV == 0) && (lvl == 0);
                if (n % DIV == 0) begin
                    if (m_sd) begin
                        res0 = (res0 + DIV * (hold0 ^ MID)) % FULL;
                        res1 = (res1 + DIV * (hold1 ^ MID)) % FULL;
                    end
                    if (lvl > 0) begin
                        f = fq.pop_front();
                        hold0 = int'(f[15:0]);
                        hold1 = int'(f[31:16]);
                    end
                    sw = (md != m_sd);
                    m_sd = md;
                    if (sw) begin res0 = 0; res1 = 0; end
                    sb.push_back('{n, m_sd, hold0 ^ MID, hold1 ^ MID, res0, res1});
                end
                if (empty_tick) m_under = 1;
                else if (c) m_under = 0;
                if (v && lvl < DEPTH) fq.push_back(d);
            end
        end
    end

    // monitor: status every cycle, output pattern and density once per completed period
    initial begin
        int j, e0, e1, mis0, mis1, ones0, ones1, lvl;
        mis0 = 0; mis1 = 0; ones0 = 0; ones1 = 0;
        forever begin
            @(negedge clk);
            if (m_live) begin
                lvl = fq.size();
                check("fifo_level", int'(fifo_level), lvl);
                check("in_ready", int'(in_ready), (rst_n && lvl < DEPTH) ? 1 : 0);
                check("underrun", int'(underrun), m_under ? 1 : 0);
                if (m_rst) check("analog_in_reset", int'(analog), 0);
                if (n == 0) begin mis0 = 0; mis1 = 0; ones0 = 0; ones1 = 0; end
                if (sb.size() > 0) begin
                    j = n - sb[0].s;
                    if (j >= 1 && j <= DIV && (sb[0].sd || j > DIV - PER)) begin
                        if (sb[0].sd) begin
                            e0 = ((sb[0].a0 + j * sb[0].u0) >> W) - ((sb[0].a0 + (j - 1) * sb[0].u0) >> W);
                            e1 = ((sb[0].a1 + j * sb[0].u1) >> W) - ((sb[0].a1 + (j - 1) * sb[0].u1) >> W);
                        end else begin
                            e0 = ((j - (DIV - PER) - 1) < (sb[0].u0 >> (W - PB))) ? 1 : 0;
                            e1 = ((j - (DIV - PER) - 1) < (sb[0].u1 >> (W - PB))) ? 1 : 0;
                        end
                        if (int'(analog[0]) != e0) mis0++;
                        if (int'(analog[1]) != e1) mis1++;
                        ones0 += int'(analog[0]);
                        ones1 += int'(analog[1]);
                    end
                    if (j == DIV) begin
                        check("ch0_pattern_errors", mis0, 0);
                        check("ch1_pattern_errors", mis1, 0);
                        check("ch0_ones", ones0, sb[0].sd ? (sb[0].a0 + DIV * sb[0].u0) >> W : sb[0].u0 >> (W - PB));
                        check("ch1_ones", ones1, sb[0].sd ? (sb[0].a1 + DIV * sb[0].u1) >> W : sb[0].u1 >> (W - PB));
                        void'(sb.pop_front());
                        mis0 = 0; mis1 = 0; ones0 = 0; ones1 = 0;
                    end
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // advance until the next edge is phase ph+1 of the sample period
    task automatic sync(input int ph);
        for (int i = 0; i < DIV + 2 && (n % DIV) != ph; i++) step(1);
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data = d;
        step(1);
        in_valid = 1'b0;
    endtask

    initial begin
        step(5);
        rst_n = 1'b1;
        step(3 * DIV + 20);
        sync(100); clr_underrun = 1'b1; step(1); clr_underrun = 1'b0; step(5);
        sync(DIV - 1); clr_underrun = 1'b1; step(1); clr_underrun = 1'b0; step(5);
        sync(10);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin in_data = $urandom; step(1); end
        in_valid = 1'b0;
        step(5 * DIV);
        sync(10); push({16'h8000, 16'h7FFF}); step(2 * DIV);
        sync(10); mode = 1'b1; push({16'hC000, 16'h0000}); step(2 * DIV);
        push($urandom); push($urandom); step(3 * DIV);
        mode = 1'b0; push($urandom); step(2 * DIV);
        for (int r = 0; r < 8; r++) begin
            int k;
            mode = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) begin step($urandom_range(0, 300)); push($urandom); end
            clr_underrun = 1'($urandom_range(0, 1)); step(1); clr_underrun = 1'b0;
            step($urandom_range(200, 700));
        end
        sync(10); mode = 1'b0;
        for (int i = 0; i < 3; i++) push($urandom);
        step(2);
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        step(3 * DIV + 20);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
